ahb_arbiter: RTL and testbench

Round-robin bus arbiter for the shared AHB fabric. It grants up to `MASTER_NUM` masters access to the single address/data path that feeds the slave decoder and read multiplexor. It tracks the address-phase owner (`HMASTER`) for the master-side multiplexors and honours locked transfers. A per-owner transfer quota keeps any one master from holding the bus indefinitely.

---
 rtl/ahb_pkg.sv | 8 +
 rtl/rr_pick.sv | 17 +
 rtl/ahb_arbiter.sv | 59 +++++
 tb/tb_ahb_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer encodings and arbiter state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  typedef enum logic [1:0] {PARK, OWN, LOCKED} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority pick, search starts just after ptr and wraps
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
  end
  assign valid = |req;
endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with lock support and per-owner transfer quota
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD = 8,
  localparam int W = $clog2(MASTER_NUM)
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [MASTER_NUM-1:0] HBUSREQ,
  input  logic [MASTER_NUM-1:0] HLOCK,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic [MASTER_NUM-1:0] HGRANT,
  output logic [W-1:0]          HMASTER,
  output logic                  HMASTLOCK
);
  localparam logic [W-1:0] DEF = W'(DEFAULT_MASTER);
  localparam logic [7:0] QUOTA = 8'(MAX_HOLD);
  arb_state_e state, state_nxt;
  logic [W-1:0] gidx, gidx_nxt, ptr, ptr_nxt, win;
  logic [7:0] cnt, cnt_nxt;
  logic win_ok, arb, others, xfer;
  rr_pick #(.N(MASTER_NUM)) u_pick (.req(HBUSREQ), .ptr(ptr), .idx(win), .valid(win_ok));
  assign others = |(HBUSREQ & ~(MASTER_NUM'(1) << gidx));
  assign xfer = HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ;
  always_comb begin
    arb = HREADY && (state == LOCKED ? !HBUSREQ[gidx] && !HLOCK[gidx]
        : !HBUSREQ[gidx] || (state == PARK && |HBUSREQ) || (state == OWN && cnt == QUOTA && others));
    gidx_nxt = !arb ? gidx : win_ok ? win : DEF;
    state_nxt = !arb ? state : !win_ok ? PARK : HLOCK[win] ? LOCKED : OWN;
    ptr_nxt = arb && win_ok ? win : ptr;
    // the quota only matters in OWN; every arbitration restarts it, including a re-win
    cnt_nxt = arb ? 8'd0 : HREADY && xfer && cnt != QUOTA ? cnt + 8'd1 : cnt;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= PARK;
      gidx <= DEF;
      ptr <= DEF;
      cnt <= '0;
      HGRANT <= MASTER_NUM'(1) << DEF;
      HMASTER <= DEF;
      HMASTLOCK <= 1'b0;
    end else begin
      state <= state_nxt;
      gidx <= gidx_nxt;
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
      HGRANT <= MASTER_NUM'(1) << gidx_nxt;
      if (HREADY) begin
        HMASTER <= gidx;
        HMASTLOCK <= HLOCK[gidx];
      end
    end
  end
endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed and random stimulus against a procedural reference model
module tb_ahb_arbiter;
  localparam int N = 4;
  localparam int MH = 2;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic [N-1:0] req = '0, lck = '0;
  logic [1:0] trans = 2'b00;
  logic [N-1:0] gnt;
  logic [1:0] hm;
  logic ml;
  int n_cmp = 0, n_bad = 0;
  int m_own, m_st, m_ptr, m_cnt, m_hm, m_ml;
  int seq[$];
  logic [N-1:0] held_gnt;
  logic [1:0] held_hm;

  always #5 clk = ~clk;

  ahb_arbiter #(.MASTER_NUM(N), .DEFAULT_MASTER(0), .MAX_HOLD(MH)) dut (
    .HCLK(clk), .HRESET(rst), .HBUSREQ(req), .HLOCK(lck), .HTRANS(trans),
    .HREADY(rdy), .HGRANT(gnt), .HMASTER(hm), .HMASTLOCK(ml)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // m_st: 0 parked, 1 owned unlocked, 2 locked
  task automatic model_step();
    int cur;
    bit others, arb, found;
    if (rst) begin
      m_own = 0; m_st = 0; m_ptr = 0; m_cnt = 0; m_hm = 0; m_ml = 0;
      return;
    end
    if (!rdy) return;
    cur = m_own;
    others = 0;
    for (int j = 0; j < N; j++) if (j != cur && req[j]) others = 1;
    if (m_st == 2) arb = !req[cur] && !lck[cur];
    else arb = !req[cur] || (m_st == 0 && req != 0) || (m_st == 1 && m_cnt == MH && others);
    m_hm = cur;
    m_ml = int'(lck[cur]);
    if (arb) begin
      found = 0;
      for (int k = 1; k <= N; k++)
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1;
          m_own = (m_ptr + k) % N;
        end
      if (found) begin
        m_ptr = m_own;
        m_st = lck[m_own] ? 2 : 1;
      end else begin
        m_own = 0;
        m_st = 0;
      end
      m_cnt = 0;
    end else if (trans[1] && m_cnt < MH) m_cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("grant", 32'(gnt), 32'(1) << m_own);
    check("hmaster", 32'(hm), 32'(m_hm));
    check("hmastlock", 32'(ml), 32'(m_ml));
    check("grant_onehot", 32'($onehot(gnt)), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; trans = 2'b10; rdy = 1'b1;
    repeat (3) cycle();
    check("rst_grant", 32'(gnt), 32'h1);
    check("rst_hmaster", 32'(hm), 32'h0);
    check("rst_mastlock", 32'(ml), 32'h0);
    rst = 1'b0; req = '0; trans = 2'b00;
    repeat (3) cycle();
    check("idle_grant", 32'(gnt), 32'h1);
    check("idle_hmaster", 32'(hm), 32'h0);
    req = 4'b0100; trans = 2'b10;
    cycle();
    check("single_grant", 32'(gnt), 32'h4);
    cycle();
    check("single_hmaster", 32'(hm), 32'h2);
    req = '0;
    cycle();
    check("drop_grant", 32'(gnt), 32'h1);
    cycle();
    do_reset();
    req = 4'b1011; trans = 2'b10;
    held_gnt = gnt;
    for (int c = 0; c < 24; c++) begin
      cycle();
      if (gnt != held_gnt) begin
        for (int j = 0; j < N; j++) if (gnt[j]) seq.push_back(j);
        held_gnt = gnt;
      end
    end
    check("rr_count", 32'(seq.size() >= 6), 32'd1);
    if (seq.size() >= 6) begin
      check("rr_0", 32'(seq[0]), 32'd1);
      check("rr_1", 32'(seq[1]), 32'd3);
      check("rr_2", 32'(seq[2]), 32'd0);
      check("rr_3", 32'(seq[3]), 32'd1);
      check("rr_4", 32'(seq[4]), 32'd3);
      check("rr_5", 32'(seq[5]), 32'd0);
    end
    req = '0;
    do_reset();
    req = 4'b1010; lck = 4'b0010;
    repeat (14) cycle();
    check("lock_grant", 32'(gnt), 32'h2);
    check("lock_mastlock", 32'(ml), 32'h1);
    lck = '0;
    repeat (3) cycle();
    check("lock_held_req", 32'(gnt), 32'h2);
    req = 4'b1000;
    cycle();
    check("lock_release", 32'(gnt), 32'h8);
    req = 4'b0101;
    repeat (2) cycle();
    rdy = 1'b0;
    held_gnt = gnt; held_hm = hm;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("wait_grant", 32'(gnt), 32'(held_gnt));
      check("wait_hmaster", 32'(hm), 32'(held_hm));
    end
    rdy = 1'b1;
    repeat (4) cycle();
    do_reset();
    req = 4'b0100;
    repeat (2) cycle();
    check("burst_hmaster", 32'(hm), 32'h2);
    rdy = 1'b0; rst = 1'b1;
    cycle();
    check("midrst_grant", 32'(gnt), 32'h1);
    check("midrst_hmaster", 32'(hm), 32'h0);
    rst = 1'b0; rdy = 1'b1; req = '0;
    cycle();
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(7) == 0) req[j] = ~req[j];
        if ($urandom_range(15) == 0) lck[j] = ~lck[j];
      end
      trans = 2'($urandom_range(3));
      rdy = $urandom_range(4) != 0;
      rst = $urandom_range(199) == 0;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
